// File: rtl/axil_traffic_master_pkg.sv
// Shared constants, FSM encoding and LFSR helpers for the AXI4-Lite traffic master.
package axil_traffic_master_pkg;

  localparam int MODE_WRCHK = 0;
  localparam int MODE_WR    = 1;
  localparam int MODE_RD    = 2;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GEN  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_NEXT = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  // One right-shifting Galois step; the bit shifted out folds the mask back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) begin
      n = n ^ LFSR_MASK;
    end else begin
      n = n;
    end
    return n;
  endfunction

  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    if (s == 32'd0) begin
      return 32'd1;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/axil_traffic_master_lfsr.sv
// 32-bit Galois LFSR with seed load; exposes the next two states combinationally
// so one transaction (address step A, data step D) is produced per advance.
module traffic_lfsr
  import axil_traffic_master_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] lfsr_a,
  output logic [31:0] lfsr_d
);

  logic [31:0] state_r;

  // Two chained steps from the current state.
  always_comb begin
    lfsr_a = lfsr_step(state_r);
    lfsr_d = lfsr_step(lfsr_a);
  end

  // State register: reseed on load, otherwise jump two steps on advance.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_r <= seed_fix(SEED);
    end else if (load) begin
      state_r <= seed_fix(seed);
    end else if (advance) begin
      state_r <= lfsr_d;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/axil_traffic_master.sv
// LFSR-driven AXI4-Lite traffic master (write / read / write-readback-check).
// Optional first-mismatch capture ports: define TRAFFIC_FIRST_ERR_CAPTURE_EN.
module axil_traffic_master
  import axil_traffic_master_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          MAX_OFFSET = 2,
  parameter int          NUM_TXN    = 32,
  parameter logic [31:0] SEED       = 32'hACE1_0001,
  parameter int          MODE       = 0
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic                  iDONE,
  input  logic [DATA_WIDTH-1:0] r_DATA,
  output logic                  w_REQ,
  output logic                  r_REQ,
  output logic [ADDR_WIDTH-1:0] w_ADDR,
  output logic [DATA_WIDTH-1:0] w_DATA,
  output logic [ADDR_WIDTH-1:0] r_ADDR,
  output logic                  oBUSY,
  output logic                  oFINISH,
  output logic                  oPASS,
  output logic [15:0]           oERR_CNT,
  output logic [15:0]           oTXN_CNT
`ifdef TRAFFIC_FIRST_ERR_CAPTURE_EN
  ,
  output logic [ADDR_WIDTH-1:0] oERR_ADDR,
  output logic [DATA_WIDTH-1:0] oERR_EXP,
  output logic [DATA_WIDTH-1:0] oERR_ACT,
  output logic                  oERR_VALID
`endif
);

  localparam int          REP       = (DATA_WIDTH + 31) / 32;
  // Keeps the region field and A[7:2]; the low two bits are forced to zero.
  localparam logic [63:0] ADDR_MASK = (64'(MAX_OFFSET) << 8) - 64'd4;

  state_t                state_r;
  state_t                state_s;
  logic                  load_s;
  logic                  adv_s;
  logic [31:0]           lfsr_a_s;
  logic [31:0]           lfsr_d_s;
  logic [ADDR_WIDTH-1:0] gen_addr_s;
  logic [DATA_WIDTH-1:0] gen_data_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic [DATA_WIDTH-1:0] cur_data_s;
  logic                  err_hit_s;
  logic                  txn_last_s;

  traffic_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .load    (load_s),
    .seed    (SEED),
    .advance (adv_s),
    .lfsr_a  (lfsr_a_s),
    .lfsr_d  (lfsr_d_s)
  );

  assign gen_addr_s = ADDR_WIDTH'({32'd0, lfsr_a_s} & ADDR_MASK);
  assign gen_data_s = DATA_WIDTH'({REP{lfsr_d_s}});
  assign err_hit_s  = (state_r == ST_RD) && iDONE && (MODE == MODE_WRCHK) && (r_DATA != data_r);
  assign txn_last_s = (({1'b0, oTXN_CNT} + 17'd1) == 17'(NUM_TXN));

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus LFSR load/advance strobes.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (iSTART) begin
          state_s = ST_GEN;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GEN: begin
        adv_s = 1'b1;
        if (MODE == MODE_RD) begin
          state_s = ST_RD;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_WR: begin
        if (iDONE) begin
          if (MODE == MODE_WRCHK) begin
            state_s = ST_RD;
          end else begin
            state_s = ST_NEXT;
          end
        end else begin
          state_s = ST_WR;
        end
      end
      ST_RD: begin
        if (iDONE) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_NEXT: begin
        if (txn_last_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_GEN;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // In GEN the fresh LFSR values are not yet registered, so forward them.
  always_comb begin
    if (state_r == ST_GEN) begin
      cur_addr_s = gen_addr_s;
      cur_data_s = gen_data_s;
    end else begin
      cur_addr_s = addr_r;
      cur_data_s = data_r;
    end
  end

  // Per-transaction address/data hold registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      addr_r <= {ADDR_WIDTH{1'b0}};
      data_r <= {DATA_WIDTH{1'b0}};
    end else if (state_r == ST_GEN) begin
      addr_r <= gen_addr_s;
      data_r <= gen_data_s;
    end else begin
      addr_r <= addr_r;
      data_r <= data_r;
    end
  end

  // Registered request, status and counter outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      w_REQ    <= 1'b0;
      r_REQ    <= 1'b0;
      w_ADDR   <= {ADDR_WIDTH{1'b0}};
      w_DATA   <= {DATA_WIDTH{1'b0}};
      r_ADDR   <= {ADDR_WIDTH{1'b0}};
      oBUSY    <= 1'b0;
      oFINISH  <= 1'b0;
      oPASS    <= 1'b0;
      oERR_CNT <= 16'd0;
      oTXN_CNT <= 16'd0;
    end else begin
      w_REQ   <= (state_s == ST_WR);
      r_REQ   <= (state_s == ST_RD);
      w_ADDR  <= (state_s == ST_WR) ? cur_addr_s : {ADDR_WIDTH{1'b0}};
      w_DATA  <= (state_s == ST_WR) ? cur_data_s : {DATA_WIDTH{1'b0}};
      r_ADDR  <= (state_s == ST_RD) ? cur_addr_s : {ADDR_WIDTH{1'b0}};
      oFINISH <= (state_s == ST_FIN);
      if (load_s) begin
        oBUSY <= 1'b1;
      end else if (state_r == ST_FIN) begin
        oBUSY <= 1'b0;
      end else begin
        oBUSY <= oBUSY;
      end
      if (state_r == ST_FIN) begin
        oPASS <= (oERR_CNT == 16'd0);
      end else begin
        oPASS <= oPASS;
      end
      if (load_s) begin
        oERR_CNT <= 16'd0;
      end else if (err_hit_s && (oERR_CNT != 16'hFFFF)) begin
        oERR_CNT <= oERR_CNT + 16'd1;
      end else begin
        oERR_CNT <= oERR_CNT;
      end
      if (load_s) begin
        oTXN_CNT <= 16'd0;
      end else if (state_r == ST_NEXT) begin
        oTXN_CNT <= oTXN_CNT + 16'd1;
      end else begin
        oTXN_CNT <= oTXN_CNT;
      end
    end
  end

`ifdef TRAFFIC_FIRST_ERR_CAPTURE_EN
  // First-mismatch capture, armed again by each new run.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oERR_ADDR  <= {ADDR_WIDTH{1'b0}};
      oERR_EXP   <= {DATA_WIDTH{1'b0}};
      oERR_ACT   <= {DATA_WIDTH{1'b0}};
      oERR_VALID <= 1'b0;
    end else if (load_s) begin
      oERR_ADDR  <= {ADDR_WIDTH{1'b0}};
      oERR_EXP   <= {DATA_WIDTH{1'b0}};
      oERR_ACT   <= {DATA_WIDTH{1'b0}};
      oERR_VALID <= 1'b0;
    end else if (err_hit_s && !oERR_VALID) begin
      oERR_ADDR  <= addr_r;
      oERR_EXP   <= data_r;
      oERR_ACT   <= r_DATA;
      oERR_VALID <= 1'b1;
    end else begin
      oERR_ADDR  <= oERR_ADDR;
      oERR_EXP   <= oERR_EXP;
      oERR_ACT   <= oERR_ACT;
      oERR_VALID <= oERR_VALID;
    end
  end
`endif

endmodule

// File: tb/tb_axil_traffic_master.sv
// Scoreboard bench for axil_traffic_master: three instances cover write-check,
// write-only (64-bit data, zero seed) and read-only with iDONE tied high.
module tb_axil_traffic_master;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic push_run(input int which, input logic [31:0] seed, input int n, input logic [63:0] amask);
    logic [31:0] s, a, d;
    exp_t e;
    s = seed;
    for (int i = 0; i < n; i++) begin
      a = m_step(s);
      d = m_step(a);
      s = d;
      e.addr = {32'd0, a} & amask;
      e.data = {d, d};
      case (which)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  // DUT0: MODE 0, 4 transactions, default seed
  logic        start0, done0, wreq0, rreq0, busy0, fin0, pass0;
  logic [31:0] rdata0, waddr0, wdata0, raddr0;
  logic [15:0] errc0, txnc0;
  // DUT1: MODE 1, 3 transactions, SEED 0, 16-bit address, 64-bit data
  logic        start1, done1, wreq1, rreq1, busy1, fin1, pass1;
  logic [63:0] rdata1, wdata1;
  logic [15:0] waddr1, raddr1, errc1, txnc1;
  // DUT2: MODE 2, 1000 transactions, iDONE tied high
  logic        start2, wreq2, rreq2, busy2, fin2, pass2;
  logic        done2 = 1'b1;
  logic [31:0] rdata2, waddr2, wdata2, raddr2;
  logic [15:0] errc2, txnc2;
`ifdef TRAFFIC_FIRST_ERR_CAPTURE_EN
  logic [31:0] eaddr0, eexp0, eact0, eaddr2, eexp2, eact2;
  logic [15:0] eaddr1;
  logic [63:0] eexp1, eact1;
  logic        evalid0, evalid1, evalid2;
`endif

  axil_traffic_master #(.MODE(0), .NUM_TXN(4)) u_dut0 (
    .iCLK(clk), .iRST(rst_n), .iSTART(start0), .iDONE(done0), .r_DATA(rdata0),
    .w_REQ(wreq0), .r_REQ(rreq0), .w_ADDR(waddr0), .w_DATA(wdata0), .r_ADDR(raddr0),
    .oBUSY(busy0), .oFINISH(fin0), .oPASS(pass0), .oERR_CNT(errc0), .oTXN_CNT(txnc0)
`ifdef TRAFFIC_FIRST_ERR_CAPTURE_EN
    , .oERR_ADDR(eaddr0), .oERR_EXP(eexp0), .oERR_ACT(eact0), .oERR_VALID(evalid0)
`endif
  );

  axil_traffic_master #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .MAX_OFFSET(4), .NUM_TXN(3),
                        .SEED(32'd0), .MODE(1)) u_dut1 (
    .iCLK(clk), .iRST(rst_n), .iSTART(start1), .iDONE(done1), .r_DATA(rdata1),
    .w_REQ(wreq1), .r_REQ(rreq1), .w_ADDR(waddr1), .w_DATA(wdata1), .r_ADDR(raddr1),
    .oBUSY(busy1), .oFINISH(fin1), .oPASS(pass1), .oERR_CNT(errc1), .oTXN_CNT(txnc1)
`ifdef TRAFFIC_FIRST_ERR_CAPTURE_EN
    , .oERR_ADDR(eaddr1), .oERR_EXP(eexp1), .oERR_ACT(eact1), .oERR_VALID(evalid1)
`endif
  );

  axil_traffic_master #(.MAX_OFFSET(8), .NUM_TXN(1000), .SEED(32'h1234_5678), .MODE(2)) u_dut2 (
    .iCLK(clk), .iRST(rst_n), .iSTART(start2), .iDONE(done2), .r_DATA(rdata2),
    .w_REQ(wreq2), .r_REQ(rreq2), .w_ADDR(waddr2), .w_DATA(wdata2), .r_ADDR(raddr2),
    .oBUSY(busy2), .oFINISH(fin2), .oPASS(pass2), .oERR_CNT(errc2), .oTXN_CNT(txnc2)
`ifdef TRAFFIC_FIRST_ERR_CAPTURE_EN
    , .oERR_ADDR(eaddr2), .oERR_EXP(eexp2), .oERR_ACT(eact2), .oERR_VALID(evalid2)
`endif
  );

  // Handler 0: echo memory, iDONE three cycles into each request, optional bit-0 corruption
  logic [31:0] mem0 [logic [31:0]];
  int   w0 = 0, wr_n0 = 0, rd_n0 = 0, bad_idx0 = -1;
  logic ovl0 = 1'b0;
  exp_t e0, last0;
  logic [31:0] bad_addr0, bad_exp0;

  initial begin : hdl0
    done0  = 1'b0;
    rdata0 = 32'd0;
    forever begin
      @(negedge clk);
      done0 = 1'b0;
      if (wreq0 && rreq0) ovl0 = 1'b1;
      if (wreq0 || rreq0) begin
        if (w0 == 2) begin
          done0 = 1'b1;
          w0 = 0;
          if (wreq0) begin
            chk("w0_expected", q0.size() > 0, 1'b1);
            if (q0.size() > 0) begin
              e0 = q0.pop_front();
              chk("w0_addr", waddr0, e0.addr);
              chk("w0_data", wdata0, {32'd0, e0.data[31:0]});
              last0 = e0;
            end
            mem0[waddr0] = wdata0;
            wr_n0++;
          end else begin
            chk("r0_addr", raddr0, last0.addr);
            if (rd_n0 == bad_idx0) begin
              bad_addr0 = last0.addr[31:0];
              bad_exp0  = last0.data[31:0];
              rdata0 = mem0[raddr0] ^ 32'd1;
            end else begin
              rdata0 = mem0[raddr0];
            end
            rd_n0++;
          end
        end else begin
          w0++;
        end
      end else begin
        w0 = 0;
      end
    end
  end

  // Handler 1: immediate iDONE, checks every write against the seed-1 stream
  int   wr_n1 = 0;
  logic rd_seen1 = 1'b0;
  exp_t e1;

  initial begin : hdl1
    done1  = 1'b0;
    rdata1 = 64'd0;
    forever begin
      @(negedge clk);
      if (rreq1) rd_seen1 = 1'b1;
      if (wreq1 && !done1) begin
        done1 = 1'b1;
        chk("w1_expected", q1.size() > 0, 1'b1);
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          chk("w1_addr", waddr1, e1.addr);
          chk("w1_data", wdata1, e1.data);
        end
        chk("w1_align", waddr1[1:0], 2'd0);
        chk("w1_range", waddr1 < 16'd1024, 1'b1);
        wr_n1++;
      end else begin
        done1 = 1'b0;
      end
    end
  end

  // Monitor 2: with iDONE high every read request lasts exactly one cycle
  int   rd_n2 = 0;
  logic wr_seen2 = 1'b0;
  exp_t e2;

  initial begin : mon2
    rdata2 = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (wreq2) wr_seen2 = 1'b1;
      if (rreq2) begin
        chk("r2_expected", q2.size() > 0, 1'b1);
        if (q2.size() > 0) begin
          e2 = q2.pop_front();
          chk("r2_addr", raddr2, e2.addr);
        end
        rd_n2++;
      end
    end
  end

  function automatic logic fin_of(input int which);
    case (which)
      0: return fin0;
      1: return fin1;
      default: return fin2;
    endcase
  endfunction

  task automatic wait_fin(input int which, input int budget, output int nfin);
    nfin = 0;
    for (int i = 0; i < budget && nfin == 0; i++) begin
      @(negedge clk);
      if (fin_of(which)) nfin++;
    end
    repeat (3) begin
      @(negedge clk);
      if (fin_of(which)) nfin++;
    end
  endtask

  task automatic start_run0(input int corrupt);
    bad_idx0 = corrupt;
    wr_n0 = 0;
    rd_n0 = 0;
    q0.delete();
    push_run(0, 32'hACE1_0001, 4, 64'h1FC);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  int nf;
  int got;

  initial begin : main
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wreq", wreq0, 1'b0);
    chk("rst_rreq", rreq0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_fin", fin0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_errc", errc0, 16'd0);
    chk("rst_txnc", txnc0, 16'd0);
    chk("rst_waddr", waddr0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // clean write/readback run, request two cycles after iSTART
    start_run0(-1);
    chk("a_busy", busy0, 1'b1);
    chk("a_lat_gen", wreq0, 1'b0);
    @(negedge clk);
    chk("a_lat_req", wreq0, 1'b1);
    wait_fin(0, 200, nf);
    chk("a_fin", nf, 1);
    chk("a_txnc", txnc0, 16'd4);
    chk("a_errc", errc0, 16'd0);
    chk("a_pass", pass0, 1'b1);
    chk("a_busy_end", busy0, 1'b0);
    chk("a_wr_n", wr_n0, 4);
    chk("a_rd_n", rd_n0, 4);
    chk("a_q_left", q0.size(), 0);

    // reset while the second write is requested
    start_run0(-1);
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(negedge clk);
      if (wreq0 && txnc0 == 16'd1) got = 1;
    end
    chk("r_reach", got, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_wreq", wreq0, 1'b0);
    chk("r_waddr", waddr0, 32'd0);
    chk("r_wdata", wdata0, 32'd0);
    chk("r_busy", busy0, 1'b0);
    chk("r_pass", pass0, 1'b0);
    chk("r_txnc", txnc0, 16'd0);
    nf = 0;
    repeat (4) begin
      @(negedge clk);
      if (fin0) nf++;
    end
    chk("r_nofin", nf, 0);
    rst_n = 1'b1;

    // restart reproduces the seed sequence from transaction 0
    start_run0(-1);
    wait_fin(0, 200, nf);
    chk("d_fin", nf, 1);
    chk("d_txnc", txnc0, 16'd4);
    chk("d_pass", pass0, 1'b1);
    chk("d_q_left", q0.size(), 0);

    // corrupted readback on transaction 2, plus an ignored mid-run iSTART
    start_run0(2);
    repeat (10) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_fin(0, 200, nf);
    chk("b_fin", nf, 1);
    chk("b_errc", errc0, 16'd1);
    chk("b_pass", pass0, 1'b0);
    chk("b_txnc", txnc0, 16'd4);
    chk("b_wr_n", wr_n0, 4);
    chk("b_q_left", q0.size(), 0);
`ifdef TRAFFIC_FIRST_ERR_CAPTURE_EN
    chk("b_evalid", evalid0, 1'b1);
    chk("b_eaddr", eaddr0, bad_addr0);
    chk("b_eexp", eexp0, bad_exp0);
    chk("b_eact", eact0, bad_exp0 ^ 32'd1);
`endif
    chk("ovl0", ovl0, 1'b0);

    // write-only, SEED 0 behaves as SEED 1
    push_run(1, 32'd1, 3, 64'h3FC);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_fin(1, 200, nf);
    chk("m1_fin", nf, 1);
    chk("m1_txnc", txnc1, 16'd3);
    chk("m1_wr_n", wr_n1, 3);
    chk("m1_no_rreq", rd_seen1, 1'b0);
    chk("m1_q_left", q1.size(), 0);
    chk("m1_pass", pass1, 1'b1);

    // read-only with iDONE tied high
    push_run(2, 32'h1234_5678, 1000, 64'h7FC);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_fin(2, 5000, nf);
    chk("m2_fin", nf, 1);
    chk("m2_txnc", txnc2, 16'd1000);
    chk("m2_errc", errc2, 16'd0);
    chk("m2_rd_n", rd_n2, 1000);
    chk("m2_no_wreq", wr_seen2, 1'b0);
    chk("m2_q_left", q2.size(), 0);
    chk("m2_pass", pass2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
